mem_port_arbiter: RTL and testbench

//  Shares one single-port unified RAM between the core's instruction-fetch and load/store

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_arb_watchdog.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and default constants for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEF_MAX_D_STREAK   = 4;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - counts BUSY cycles and flags the cycle an access must be aborted
module mem_arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_q holds the number of BUSY cycles already completed, so the
    // TIMEOUT_CYCLES-th BUSY cycle is the one that expires.
    assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port RAM between fetch and load/store requesters
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_D_STREAK   = DEF_MAX_D_STREAK
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_err
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned STK_W  = $clog2(MAX_D_STREAK + 1);

    state_e              state_q, state_d;
    owner_e              owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                err_q;
    logic                bus_err_q;
    logic [STK_W-1:0]    streak_q, streak_d;

    logic                grant_any;
    logic                grant_is_d;
    logic                wd_expired;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (state_q != ST_BUSY),
        .enable_i  (state_q == ST_BUSY),
        .expired_o (wd_expired)
    );

    always_comb begin
        grant_any  = i_req | d_req;
        grant_is_d = d_req && !(i_req && (streak_q == STK_W'(MAX_D_STREAK)));
        state_d    = state_q;
        streak_d   = streak_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d = ST_BUSY;
                    // The streak only measures how long fetch has actually been waiting.
                    if (grant_is_d && i_req) begin
                        if (streak_q != STK_W'(MAX_D_STREAK)) begin
                            streak_d = streak_q + STK_W'(1);
                        end
                    end else begin
                        streak_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ready || wd_expired) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q   <= OWN_I;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && grant_any) begin
                if (grant_is_d) begin
                    owner_q <= OWN_D;
                    we_q    <= d_we;
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                    wstrb_q <= d_wstrb;
                end else begin
                    owner_q <= OWN_I;
                    we_q    <= 1'b0;
                    addr_q  <= i_addr;
                    wdata_q <= '0;
                    wstrb_q <= '0;
                end
            end
            // A RAM answer in the expiry cycle still counts as a normal completion.
            if (state_q == ST_BUSY) begin
                if (mem_ready) begin
                    err_q <= 1'b0;
                    if (owner_q == OWN_D) begin
                        d_rdata_q <= mem_rdata;
                    end else begin
                        i_rdata_q <= mem_rdata;
                    end
                end else if (wd_expired) begin
                    err_q     <= 1'b1;
                    bus_err_q <= 1'b1;
                    if (owner_q == OWN_D) begin
                        d_rdata_q <= '0;
                    end else begin
                        i_rdata_q <= '0;
                    end
                end
            end
        end
    end

    assign i_ack     = (state_q == ST_RESP) && (owner_q == OWN_I);
    assign d_ack     = (state_q == ST_RESP) && (owner_q == OWN_D);
    assign i_err     = i_ack && err_q;
    assign d_err     = d_ack && err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

    assign mem_req   = (state_q == ST_BUSY);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = mem_we ? wstrb_q : '0;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ram_wait = 0;
    int          busy_cnt = 0;
    logic [31:0] ram_rdata = 32'h0;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8),
        .MAX_D_STREAK   (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM answers in the (ram_wait+1)-th BUSY cycle of each access.
    always begin
        @(posedge clock);
        #1;
        if (mem_req) begin
            mem_ready = (busy_cnt == ram_wait);
            mem_rdata = mem_ready ? ram_rdata : 32'h0BAD0BAD;
            busy_cnt  = busy_cnt + 1;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'h0;
            busy_cnt  = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        step();
        step();
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_i_ack", i_ack, 0);
        check_eq("rst_d_ack", d_ack, 0);
        check_eq("rst_bus_err", bus_err, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        reset = 1'b1;

        // 1: single fetch, zero-wait RAM
        i_addr = 32'h100; ram_rdata = 32'h00500093; ram_wait = 0; i_req = 1'b1;
        step();
        check_eq("t1_mem_req", mem_req, 1);
        check_eq("t1_mem_addr", mem_addr, 32'h100);
        check_eq("t1_mem_we", mem_we, 0);
        check_eq("t1_mem_wstrb", mem_wstrb, 0);
        check_eq("t1_i_ack_early", i_ack, 0);
        step();
        check_eq("t1_i_ack", i_ack, 1);
        check_eq("t1_i_rdata", i_rdata, 32'h00500093);
        check_eq("t1_i_err", i_err, 0);
        check_eq("t1_d_ack", d_ack, 0);
        i_req = 1'b0;
        step();
        check_eq("t1_i_ack_drop", i_ack, 0);
        check_eq("t1_mem_req_idle", mem_req, 0);

        // 2: store with 3 wait states; data changed after grant must be ignored
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        ram_wait = 3; ram_rdata = 32'h12345678;
        for (int c = 1; c <= 4; c++) begin
            step();
            check_eq($sformatf("t2_mem_req_c%0d", c), mem_req, 1);
            check_eq($sformatf("t2_mem_we_c%0d", c), mem_we, 1);
            check_eq($sformatf("t2_mem_wstrb_c%0d", c), mem_wstrb, 4'b0011);
            check_eq($sformatf("t2_mem_wdata_c%0d", c), mem_wdata, 32'hDEADBEEF);
            check_eq($sformatf("t2_mem_addr_c%0d", c), mem_addr, 32'h2000);
            check_eq($sformatf("t2_d_ack_c%0d", c), d_ack, 0);
            if (c == 1) d_wdata = 32'h0;
        end
        step();
        check_eq("t2_d_ack", d_ack, 1);
        check_eq("t2_d_err", d_err, 0);
        check_eq("t2_d_rdata", d_rdata, 32'h12345678);
        check_eq("t2_i_ack", i_ack, 0);
        check_eq("t2_mem_req_resp", mem_req, 0);
        d_req = 1'b0; d_we = 1'b0;
        step();

        // 3: both requesters held high, streak limit 4 -> D,D,D,D,I,D,D,D,D,I
        i_addr = 32'h100; d_addr = 32'h2000; d_we = 1'b0; ram_wait = 0; ram_rdata = 32'hCAFE0001;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check_eq($sformatf("t3_grant_addr_%0d", k), mem_addr, (k % 5 == 4) ? 32'h100 : 32'h2000);
            step();
            check_eq($sformatf("t3_i_ack_%0d", k), i_ack, (k % 5 == 4) ? 1 : 0);
            check_eq($sformatf("t3_d_ack_%0d", k), d_ack, (k % 5 == 4) ? 0 : 1);
            if (k == 9) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            step();
        end

        // 4: RAM never answers, timeout 8 BUSY cycles
        ram_wait = 1000; ram_rdata = 32'h77777777; i_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            check_eq($sformatf("t4_mem_req_c%0d", c), mem_req, 1);
            check_eq($sformatf("t4_i_ack_c%0d", c), i_ack, 0);
        end
        step();
        check_eq("t4_i_ack", i_ack, 1);
        check_eq("t4_i_err", i_err, 1);
        check_eq("t4_i_rdata", i_rdata, 0);
        check_eq("t4_bus_err", bus_err, 1);
        i_req = 1'b0;
        step();
        ram_wait = 0; ram_rdata = 32'h00000042; d_req = 1'b1; d_we = 1'b0;
        step();
        step();
        check_eq("t4_good_d_ack", d_ack, 1);
        check_eq("t4_good_d_err", d_err, 0);
        check_eq("t4_good_d_rdata", d_rdata, 32'h00000042);
        check_eq("t4_bus_err_sticky", bus_err, 1);
        d_req = 1'b0;
        step();

        // 5: reset during BUSY, pending fetch served after release
        ram_wait = 1000; i_req = 1'b1;
        step();
        step();
        check_eq("t5_mem_req_busy", mem_req, 1);
        reset = 1'b0;
        #1;
        check_eq("t5_mem_req_rst", mem_req, 0);
        check_eq("t5_bus_err_rst", bus_err, 0);
        check_eq("t5_i_ack_rst", i_ack, 0);
        check_eq("t5_d_ack_rst", d_ack, 0);
        ram_wait = 0; ram_rdata = 32'h00000055;
        step();
        step();
        check_eq("t5_mem_req_hold", mem_req, 0);
        reset = 1'b1;
        step();
        check_eq("t5_mem_req", mem_req, 1);
        check_eq("t5_i_ack_early", i_ack, 0);
        step();
        check_eq("t5_i_ack", i_ack, 1);
        check_eq("t5_i_err", i_err, 0);
        check_eq("t5_i_rdata", i_rdata, 32'h00000055);
        i_req = 1'b0;
        step();

        // 6: RAM answers in the exact timeout cycle -> normal completion
        ram_wait = 7; ram_rdata = 32'h600D600D; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        for (int c = 1; c <= 8; c++) begin
            step();
            check_eq($sformatf("t6_mem_req_c%0d", c), mem_req, 1);
            check_eq($sformatf("t6_d_ack_c%0d", c), d_ack, 0);
        end
        step();
        check_eq("t6_d_ack", d_ack, 1);
        check_eq("t6_d_err", d_err, 0);
        check_eq("t6_d_rdata", d_rdata, 32'h600D600D);
        check_eq("t6_bus_err", bus_err, 0);
        d_req = 1'b0;
        step();
        check_eq("t6_mem_req_idle", mem_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
